// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing one two-port RAM among NREQ requesters.
// Grants up to two requests per cycle (port A, then port B), blocks same-address hazards, and registers read data per requester.
module dpram_arbiter #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 48,
  parameter int NREQ   = 4,
  localparam int AW    = $clog2(HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [NREQ*WIDTH-1:0] rdata,
  output logic [NREQ-1:0]       oor_err,
  output logic [AW-1:0]         ram_addr_a,
  output logic [AW-1:0]         ram_addr_b,
  output logic [WIDTH-1:0]      ram_data_a,
  output logic [WIDTH-1:0]      ram_data_b,
  output logic                  ram_we_a,
  output logic                  ram_we_b,
  input  logic [WIDTH-1:0]      ram_q_a,
  input  logic [WIDTH-1:0]      ram_q_b
);

  localparam int PW = $clog2(NREQ);

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NREQ);
  endfunction

  logic [AW-1:0]    addr_arr  [NREQ];
  logic [WIDTH-1:0] wdata_arr [NREQ];
  logic [NREQ-1:0]  oor_vec;
  logic [NREQ-1:0]  conflict;
  logic [NREQ-1:0]  gnt_a_vec;
  logic [NREQ-1:0]  gnt_b_vec;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] a_idx, b_idx;
  logic          a_found, b_found;
  logic          a_sel, b_sel;

  logic [NREQ-1:0]  rvalid_q, rvalid_d;
  logic [NREQ-1:0]  oor_q, oor_d;
  logic [WIDTH-1:0] rdata_q [NREQ];
  logic [WIDTH-1:0] rdata_d [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr[gi*AW +: AW];
      assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
      assign oor_vec[gi]   = int'(addr_arr[gi]) >= HEIGHT;
    end
  endgenerate

  // Port A: first requester found scanning circularly from the pointer.
  always_comb begin
    a_found = 1'b0;
    a_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!a_found && req[wrap(int'(ptr_q) + k)]) begin
        a_found = 1'b1;
        a_idx   = wrap(int'(ptr_q) + k);
      end
    end
  end

  // Raw addresses are compared, so out-of-range entries still block hazards.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_conflict
      assign conflict[gi] = (addr_arr[gi] == addr_arr[a_idx]) && (we[gi] || we[a_idx]);
    end
  endgenerate

  // Port B: continue after A, skipping requesters that clash with A.
  always_comb begin
    b_found = 1'b0;
    b_idx   = '0;
    for (int k = 1; k < NREQ; k++) begin
      if (!b_found && req[wrap(int'(a_idx) + k)] && !conflict[wrap(int'(a_idx) + k)]) begin
        b_found = 1'b1;
        b_idx   = wrap(int'(a_idx) + k);
      end
    end
  end

  assign a_sel = a_found && !rst;
  assign b_sel = b_found && a_sel;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign gnt_a_vec[gi] = a_sel && (a_idx == PW'(gi));
      assign gnt_b_vec[gi] = b_sel && (b_idx == PW'(gi));
      assign gnt[gi]       = gnt_a_vec[gi] || gnt_b_vec[gi];
    end
  endgenerate

  always_comb begin
    ram_addr_a = '0;
    ram_data_a = '0;
    ram_we_a   = 1'b0;
    ram_addr_b = '0;
    ram_data_b = '0;
    ram_we_b   = 1'b0;
    if (a_sel) begin
      ram_addr_a = addr_arr[a_idx];
      ram_data_a = wdata_arr[a_idx];
      ram_we_a   = we[a_idx] && !oor_vec[a_idx];
    end
    if (b_sel) begin
      ram_addr_b = addr_arr[b_idx];
      ram_data_b = wdata_arr[b_idx];
      ram_we_b   = we[b_idx] && !oor_vec[b_idx];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (b_sel) begin
      ptr_d = wrap(int'(b_idx) + 1);
    end else if (a_sel) begin
      ptr_d = wrap(int'(a_idx) + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Per-requester response registers; rdata holds until the next granted read.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_resp
      always_comb begin
        rvalid_d[gi] = gnt[gi] && !we[gi];
        oor_d[gi]    = gnt[gi] && oor_vec[gi];
        rdata_d[gi]  = rdata_q[gi];
        if (gnt[gi] && !we[gi]) begin
          if (oor_vec[gi]) begin
            rdata_d[gi] = '0;
          end else if (gnt_a_vec[gi]) begin
            rdata_d[gi] = ram_q_a;
          end else begin
            rdata_d[gi] = ram_q_b;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_q[gi] <= 1'b0;
          oor_q[gi]    <= 1'b0;
          rdata_q[gi]  <= '0;
        end else begin
          rvalid_q[gi] <= rvalid_d[gi];
          oor_q[gi]    <= oor_d[gi];
          rdata_q[gi]  <= rdata_d[gi];
        end
      end

      assign rdata[gi*WIDTH +: WIDTH] = rdata_q[gi];
    end
  endgenerate

  assign rvalid  = rvalid_q;
  assign oor_err = oor_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed-vector bench for dpram_arbiter with a behavioural two-port RAM.
// Stimulus pushes expected responses into a scoreboard; a monitor pops and compares them.
module tb_dpram_arbiter;

  localparam int WIDTH  = 32;
  localparam int HEIGHT = 48;
  localparam int NREQ   = 4;
  localparam int AW     = 6;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0]       we  = '0;
  logic [NREQ*AW-1:0]    addr  = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic [NREQ-1:0]       gnt, rvalid, oor_err;
  logic [NREQ*WIDTH-1:0] rdata;
  logic [AW-1:0]         ram_addr_a, ram_addr_b;
  logic [WIDTH-1:0]      ram_data_a, ram_data_b, ram_q_a, ram_q_b;
  logic                  ram_we_a, ram_we_b;

  logic [WIDTH-1:0] mem [64];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int           cyc;
    logic [3:0]   rv;
    logic [3:0]   oor;
    logic [127:0] d;
  } exp_t;
  exp_t sb[$];

  dpram_arbiter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .oor_err(oor_err),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: initialised under reset to A000_0000+index, RAM[5]=DEADBEEF.
  assign ram_q_a = mem[ram_addr_a];
  assign ram_q_b = mem[ram_addr_b];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      mem[5] <= 32'hDEAD_BEEF;
    end else begin
      if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    end
  end

  function automatic logic [23:0] pa(input int a3, input int a2, input int a1, input int a0);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic apply(input string nm, input logic r, input logic [3:0] rq, input logic [3:0] w,
                       input logic [23:0] ad, input logic [127:0] wd,
                       input logic [3:0] eg, input logic ewa, input logic ewb,
                       input logic [3:0] erv, input logic [3:0] eoor, input logic [127:0] ed);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; we = w; addr = ad; wdata = wd;
    #1;
    $display("[%0d] %s rst=%b req=%b we=%b gnt=%b we_a=%b we_b=%b", cyc, nm, r, rq, w, gnt, ram_we_a, ram_we_b);
    chk({nm, ".gnt"}, 128'(gnt), 128'(eg));
    chk({nm, ".ram_we_a"}, 128'(ram_we_a), 128'(ewa));
    chk({nm, ".ram_we_b"}, 128'(ram_we_b), 128'(ewb));
    if ((erv | eoor) != 4'b0) begin
      e.cyc = cyc + 1; e.rv = erv; e.oor = eoor; e.d = ed;
      sb.push_back(e);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT responds or one falls due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((rvalid != 4'b0) || (oor_err != 4'b0) || (sb.size() > 0 && sb[0].cyc <= cyc)) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_resp: got rvalid=%b oor_err=%b expected none (cycle %0d)", rvalid, oor_err, cyc);
        end else begin
          e = sb.pop_front();
          chk("resp.cycle", 128'(cyc), 128'(e.cyc));
          chk("resp.rvalid", 128'(rvalid), 128'(e.rv));
          chk("resp.oor_err", 128'(oor_err), 128'(e.oor));
          for (int i = 0; i < NREQ; i++)
            if (e.rv[i]) chk($sformatf("resp.rdata%0d", i), 128'(rdata[i*WIDTH +: WIDTH]), 128'(e.d[i*32 +: 32]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply("reset0", 1, 4'b0100, 4'b0000, pa(0,5,0,0), '0, 4'b0000, 0, 0, 4'b0, 4'b0, '0);
    apply("reset1", 1, 4'b0000, 4'b0000, '0, '0, 4'b0000, 0, 0, 4'b0, 4'b0, '0);
    apply("idle", 0, 4'b0000, 4'b0000, '0, '0, 4'b0000, 0, 0, 4'b0, 4'b0, '0);
    chk("reset.rvalid", 128'(rvalid), 128'(0));
    chk("reset.oor_err", 128'(oor_err), 128'(0));
    chk("reset.rdata", 128'(rdata), 128'(0));

    // Single read; pointer then sits at 3.
    apply("rd_single", 0, 4'b0100, 4'b0000, pa(0,5,0,0), '0, 4'b0100, 0, 0,
          4'b0100, 4'b0, {32'h0, 32'hDEAD_BEEF, 64'h0});
    // All four reading different addresses.
    apply("rd_all_a", 0, 4'b1111, 4'b0000, pa(13,12,11,10), '0, 4'b1001, 0, 0,
          4'b1001, 4'b0, {32'hA000_000D, 64'h0, 32'hA000_000A});
    apply("rd_all_b", 0, 4'b1111, 4'b0000, pa(13,12,11,10), '0, 4'b0110, 0, 0,
          4'b0110, 4'b0, {32'h0, 32'hA000_000C, 32'hA000_000B, 32'h0});
    apply("rd_3", 0, 4'b1000, 4'b0000, pa(13,0,0,0), '0, 4'b1000, 0, 0,
          4'b1000, 4'b0, {32'hA000_000D, 96'h0});
    // Write/read conflict on address 7 with pointer at 0.
    apply("conf_1", 0, 4'b0011, 4'b0001, pa(0,0,7,7), {96'h0, 32'h11}, 4'b0001, 1, 0,
          4'b0, 4'b0, '0);
    apply("conf_2", 0, 4'b0011, 4'b0001, pa(0,0,7,7), {96'h0, 32'h11}, 4'b0010, 0, 0,
          4'b0010, 4'b0, {64'h0, 32'h11, 32'h0});
    // Same-address reads, twice back-to-back.
    apply("rr_same_a", 0, 4'b1010, 4'b0000, pa(9,0,9,0), '0, 4'b1010, 0, 0,
          4'b1010, 4'b0, {32'hA000_0009, 32'h0, 32'hA000_0009, 32'h0});
    apply("rr_same_b", 0, 4'b1010, 4'b0000, pa(9,0,9,0), '0, 4'b1010, 0, 0,
          4'b1010, 4'b0, {32'hA000_0009, 32'h0, 32'hA000_0009, 32'h0});
    // Out-of-range write then read.
    apply("oor_wr", 0, 4'b0001, 4'b0001, pa(0,0,0,50), {96'h0, 32'h0BAD}, 4'b0001, 0, 0,
          4'b0, 4'b0001, '0);
    apply("oor_rd", 0, 4'b0010, 4'b0000, pa(0,0,60,0), '0, 4'b0010, 0, 0,
          4'b0010, 4'b0010, '0);
    // Read on A with a write on B, then read back the written word.
    apply("rd_a_wr_b", 0, 4'b1100, 4'b1000, pa(20,21,0,0), {32'h33, 96'h0}, 4'b1100, 0, 1,
          4'b0100, 4'b0, {32'h0, 32'hA000_0015, 64'h0});
    apply("rd_back", 0, 4'b0001, 4'b0000, pa(0,0,0,20), '0, 4'b0001, 0, 0,
          4'b0001, 4'b0, {96'h0, 32'h33});
    apply("idle", 0, 4'b0000, 4'b0000, '0, '0, 4'b0000, 0, 0, 4'b0, 4'b0, '0);
    chk("oor.ram50_unchanged", 128'(mem[50]), 128'(32'hA000_0032));
    chk("hold.rdata", 128'(rdata), {32'hA000_0009, 32'hA000_0015, 32'h0, 32'h33});

    // Reset with all requesters writing; nothing may be granted.
    apply("mid_rst0", 1, 4'b1111, 4'b1111, pa(13,12,11,10), '1, 4'b0000, 0, 0, 4'b0, 4'b0, '0);
    apply("mid_rst1", 1, 4'b1111, 4'b1111, pa(13,12,11,10), '1, 4'b0000, 0, 0, 4'b0, 4'b0, '0);
    chk("mid_rst.rdata", 128'(rdata), 128'(0));
    chk("mid_rst.rvalid", 128'(rvalid), 128'(0));
    apply("post_rst", 0, 4'b1111, 4'b0000, pa(13,12,11,10), '0, 4'b0011, 0, 0,
          4'b0011, 4'b0, {64'h0, 32'hA000_000B, 32'hA000_000A});
    apply("idle", 0, 4'b0000, 4'b0000, '0, '0, 4'b0000, 0, 0, 4'b0, 4'b0, '0);
    apply("idle", 0, 4'b0000, 4'b0000, '0, '0, 4'b0000, 0, 0, 4'b0, 4'b0, '0);
    @(negedge clk);
    #2;
    chk("scoreboard.drained", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
- Round-robin arbiter that shares one two-port RAM (port A, port B, combinational read, per-port write enable) among NREQ requesters.
- Grants up to two requests per cycle, one per RAM port.
- Prevents same-address hazards between the two ports.
- Returns registered read data to each requester; sits between requesting engines and the RAM instance.

Parameters:
- WIDTH, 32, data word width.
- HEIGHT, 48, RAM depth in words; AW = $clog2(HEIGHT) is a derived localparam.
- NREQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req  in  NREQ  per-requester request, level
- we  in  NREQ  per-requester write (1) / read (0)
- addr  in  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
- wdata  in  NREQ*WIDTH  flattened write data
- gnt  out  NREQ  combinational grant; the request is consumed at this edge
- rvalid  out  NREQ  registered, pulses 1 cycle after a granted read
- rdata  out  NREQ*WIDTH  registered read data per requester, held until that requester's next read
- oor_err  out  NREQ  registered, pulses 1 cycle after a granted out-of-range access
- ram_addr_a, ram_addr_b  out  AW  RAM addresses
- ram_data_a, ram_data_b  out  WIDTH  RAM write data
- ram_we_a, ram_we_b  out  1  RAM write enables
- ram_q_a, ram_q_b  in  WIDTH  RAM combinational read data

Behaviour:
- Reset (rst=1 at edge):
  - ptr=0; rvalid=0; oor_err=0; rdata=0.
  - While rst=1, gnt=0 and ram_we_a/b=0 combinationally.
  - A request pending during reset is dropped, not queued; the requester must hold req.
- Port A selection: the first i with req[i]=1, scanning circularly from ptr.
- Port B selection: continue scanning circularly after A's index and pick the first request that is not in conflict with A.
  - Conflict: addr equal to A's addr AND (we of either = 1).
  - Read-read to the same address is not a conflict; both are granted.
  - Conflicting candidates are skipped (not granted) this cycle.
- At most one grant per requester per cycle; a single requester never gets both ports.
- Idle port drives addr=0, data=0, we=0.
- Pointer update:
  - 2 grants: ptr <= (B index + 1) mod NREQ.
  - 1 grant: ptr <= (A index + 1) mod NREQ.
  - 0 grants: ptr unchanged.
- Write: on a granted write, ram_we=1 and ram_data=wdata in the same cycle; the RAM updates at that edge. No response is generated except oor_err.
- Read:
  - Latency 1. At the grant edge, rdata[i] <= port q and rvalid[i] <= 1.
  - rvalid[i] is deasserted the next cycle unless re-granted.
  - Back-to-back reads from one requester produce rvalid high on consecutive cycles.
- Out-of-range (addr >= HEIGHT):
  - Still granted, and ram_we is forced 0.
  - A read loads rdata with 0 and pulses rvalid.
  - oor_err[i] pulses 1 cycle after the grant for both reads and writes.
  - Out-of-range entries still take part in conflict checks by raw addr.
- Starvation: every requester holding req is granted within ceil(NREQ/2)+1 cycles, worst case including a conflict skip.
- A request that drops without gnt is simply withdrawn; there is no side effect.

Test Plan:
- Reset then single read: preload RAM[5]=0xDEADBEEF, req[2]=1, we=0, addr=5 -> gnt[2] same cycle, next cycle rvalid[2]=1, rdata[2]=0xDEADBEEF, ptr=3.
- All four requesters read different addresses continuously -> grants {0,1}, {2,3}, {0,1}, ...; each rvalid pulses every other cycle.
- Conflict: req0 writes addr 7 (0x11), req1 reads addr 7, ptr=0 -> cycle 1 gnt=0001, only port A active; cycle 2 gnt[1] granted, next rdata[1]=0x11.
- Same-address reads: req1 and req3 read addr 9 -> both granted the same cycle, both rdata equal RAM[9].
- Out-of-range: req0 writes addr 50 (HEIGHT=48) -> gnt[0]=1, ram_we_a=0, oor_err[0]=1 next cycle, RAM unchanged.
- Reset mid-operation: assert rst while req=1111 -> gnt=0000 and we=0 that cycle; after release, ptr=0 so gnt=0011 first.
